dcache_lsq: RTL

- Load/store queue that accepts the data cache's miss, evict and uncached-store requests and buffers them in order.
- Issues the buffered requests one at a time to the memory bus.
- Returns read and fill data to the cache on the mem_* response interface; the cache consumes that data with mem_read.
- Sits between dcache and the memory/bus controller, acting as the responder end of the cache's out_* request channel.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/lsq_fifo.sv | 68 ++++++
 rtl/dcache_lsq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
//==============================================================================
// Module   : dcache_pkg
// Brief    : Shared constants, FSM encoding and queue-entry layout for the
//            dcache load/store queue.
// Revision : 1.0 - initial release
//==============================================================================
package dcache_pkg;

    localparam logic [2:0] SZ_LINE = 3'h7;
    localparam logic       RW_LD   = 1'b0;
    localparam logic       RW_ST   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsq_state_e;

    // Entry packs as {reqcycles, size, data, addr, cacheable, rdwr}, LSB last.
    localparam int ENT_RDWR = 0;
    localparam int ENT_CACH = 1;
    localparam int ENT_ADDR = 2;

    function automatic int ent_data_lsb(input int aw);
        return ENT_ADDR + aw;
    endfunction

    function automatic int ent_size_lsb(input int aw, input int dw);
        return ENT_ADDR + aw + dw;
    endfunction

    function automatic int ent_width(input int aw, input int dw);
        return ENT_ADDR + aw + dw + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsq_fifo.sv
`default_nettype none
//==============================================================================
// Module   : lsq_fifo
// Brief    : Circular FIFO with wrapping head/tail pointers and occupancy count.
// Revision : 1.0 - initial release
//==============================================================================
module lsq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop_ok) begin
                head_q <= head_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_lsq.sv
`default_nettype none
//==============================================================================
// Module   : dcache_lsq
// Brief    : In-order load/store queue between dcache and the memory bus; one
//            outstanding bus transaction, load data returned on mem_*.
//            Optional macro LSQ_BYPASS_EN: empty idle queue issues directly.
// Revision : 1.0 - initial release
//==============================================================================
module dcache_lsq
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 15,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rd,
    input  logic          in_rdwr,
    input  logic          in_cacheable,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    in_size,
    input  logic          in_reqcycles,
    output logic          lsq_full,
    output logic          bus_req,
    input  logic          bus_ack,
    output logic          bus_rdwr,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [2:0]    bus_size,
    output logic          bus_reqcycles,
    input  logic          bus_done,
    input  logic [DW-1:0] bus_rdata,
    output logic          mem_vld,
    input  logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_cacheable
);

    localparam int EW = ent_width(AW, DW);
    localparam int DL = ent_data_lsb(AW);
    localparam int SL = ent_size_lsb(AW, DW);
    localparam int CW = $clog2(DEPTH) + 1;

    lsq_state_e    state_q, state_d;
    logic [EW-1:0] in_entry;
    logic [EW-1:0] head_entry;
    logic [EW-1:0] iss_q, iss_d;
    logic [CW-1:0] fifo_count;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic          bypass, txn_done, iss_is_load;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_data_q;
    logic          mem_cach_q;

    assign in_entry = {in_reqcycles, in_size, in_data, in_addr, in_cacheable, in_rdwr};
    assign in_rd    = in_vld & ~fifo_full;
    assign lsq_full = (fifo_count == CW'(DEPTH));

`ifdef LSQ_BYPASS_EN
    assign bypass = (state_q == ST_IDLE) & fifo_empty & in_rd;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = in_rd & ~bypass;
    assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

    lsq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign iss_is_load = (iss_q[ENT_RDWR] == RW_LD);
    // An ack and done in the same cycle completes the transaction outright.
    assign txn_done = bus_done & (((state_q == ST_ISSUE) & bus_ack) | (state_q == ST_WAIT));

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        case (state_q)
            ST_IDLE: begin
                if (bypass) begin
                    iss_d   = in_entry;
                    state_d = ST_ISSUE;
                end else if (fifo_pop) begin
                    iss_d   = head_entry;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_WAIT;
            end
            ST_RESP: begin
                if (mem_read) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (txn_done) begin
            state_d = iss_is_load ? ST_RESP : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            iss_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_cach_q <= 1'b0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            if (txn_done && iss_is_load) begin
                mem_addr_q <= iss_q[ENT_ADDR +: AW];
                mem_data_q <= bus_rdata;
                mem_cach_q <= iss_q[ENT_CACH];
            end
        end
    end

    assign bus_req       = (state_q == ST_ISSUE);
    assign bus_rdwr      = iss_q[ENT_RDWR];
    assign bus_addr      = iss_q[ENT_ADDR +: AW];
    assign bus_wdata     = iss_q[DL +: DW];
    assign bus_size      = iss_q[SL +: 3];
    assign bus_reqcycles = iss_q[EW-1];

    assign mem_vld       = (state_q == ST_RESP);
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign mem_cacheable = mem_cach_q;

endmodule
`default_nettype wire
